// File: rtl/wd_sigverify_pkg.sv
// Shared constants and types for the signature-verify datapath.
// Holds the Ed25519 field prime and the serial multiplier FSM state type.
package wd_sigverify_pkg;

  localparam logic [254:0] ED25519_P =
    255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_e;

endpackage

// File: rtl/ed25519_mul_modp_serial_if.sv
// Request/response handshake bundle for the serial modular multiplier.
interface ed25519_mul_modp_serial_if #(
  parameter int unsigned W = 255,
  parameter int unsigned M = 128
);
  logic         in_v;
  logic         in_r;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [M-1:0] m_i;
  logic         out_v;
  logic         out_r;
  logic [W-1:0] out0;
  logic [M-1:0] m_o;

  modport master (
    output in_v, in0, in1, m_i, out_r,
    input  in_r, out_v, out0, m_o
  );

  modport slave (
    input  in_v, in0, in1, m_i, out_r,
    output in_r, out_v, out0, m_o
  );
endinterface

// File: rtl/ed25519_dbl_add_modp.sv
// One double-and-add step of MSB-first modular multiplication.
// Inputs are canonical (< P); acc_next = (2*acc + (b ? in1 : 0)) mod P.
module ed25519_dbl_add_modp
  import wd_sigverify_pkg::*;
#(
  parameter int unsigned W = 255
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] in1,
  input  logic         b,
  output logic [W-1:0] acc_next
);

  localparam logic [W:0] P_EXT = (W+1)'(ED25519_P);

  logic [W:0] dbl;
  logic [W:0] dbl_red;
  logic [W:0] sum;
  logic [W:0] sum_red;

  always_comb begin
    dbl      = {acc, 1'b0};
    dbl_red  = (dbl >= P_EXT) ? (dbl - P_EXT) : dbl;
    sum      = dbl_red + (b ? {1'b0, in1} : '0);
    sum_red  = (sum >= P_EXT) ? (sum - P_EXT) : sum;
    acc_next = W'(sum_red);
  end

endmodule

// File: rtl/ed25519_mul_modp_serial.sv
// Bit-serial multiplier computing in0*in1 mod (2^255-19), one multiplier bit
// per cycle MSB first; result and metadata held until the consumer takes them.
module ed25519_mul_modp_serial
  import wd_sigverify_pkg::*;
#(
  parameter int unsigned W = 255,
  parameter int unsigned M = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  ed25519_mul_modp_serial_if.slave    bus
);

  localparam int unsigned CW  = $clog2(W);
  localparam logic [W-1:0] P_W = W'(ED25519_P);

  mul_state_e    state_q, state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  out0_q;
  logic [M-1:0]  m_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  in1_red;

  // The multiplicand is always < 2P, so one subtraction makes it canonical.
  assign in1_red = (bus.in1 >= P_W) ? (bus.in1 - P_W) : bus.in1;

  ed25519_dbl_add_modp #(.W(W)) u_step (
    .acc      (acc_q),
    .in1      (b_q),
    .b        (a_q[cnt_q]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_v)       state_d = RUN;
      RUN:     if (cnt_q == '0)    state_d = DONE;
      DONE:    if (bus.out_r)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_r  = (state_q == IDLE);
    bus.out_v = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      out0_q <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_v) begin
            a_q   <= bus.in0;
            b_q   <= in1_red;
            m_q   <= bus.m_i;
            acc_q <= '0;
            cnt_q <= CW'(W-1);
          end
        end
        RUN: begin
          acc_q <= acc_next;
          if (cnt_q == '0) out0_q <= acc_next;
          else             cnt_q  <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out0 = out0_q;
  assign bus.m_o  = m_q;

endmodule

// File: tb/tb_ed25519_mul_modp_serial.sv
// Self-checking bench for the serial Ed25519 modular multiplier against a
// wide-integer reference (full product, then remainder by the prime).
module tb_ed25519_mul_modp_serial;

  localparam int unsigned W = 255;
  localparam int unsigned M = 128;
  localparam int unsigned N_RAND = 200;
  localparam int unsigned BUDGET = 1000;
  localparam logic [W-1:0] P_TB = {W{1'b1}} - W'(18);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ed25519_mul_modp_serial_if #(.W(W), .M(M)) bus ();

  ed25519_mul_modp_serial #(.W(W), .M(M)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod, pw, rem;
    pw   = (2*W)'(1) << 255;
    pw   = pw - (2*W)'(19);
    prod = (2*W)'(a) * (2*W)'(b);
    rem  = prod % pw;
    return W'(rem);
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return W'(r);
  endfunction

  function automatic logic [M-1:0] rand_m();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom();
    return M'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges from the accept edge (inclusive) to the edge after which
  // out_v is first seen high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [M-1:0] m, input int unsigned stall,
                        output logic [W-1:0] res, output logic [M-1:0] mo,
                        output int unsigned lat, output bit timeout);
    int unsigned n;
    timeout  = 1'b0;
    bus.in0  = a;
    bus.in1  = b;
    bus.m_i  = m;
    bus.in_v = 1'b1;
    n = 0;
    while (!bus.in_r && n < BUDGET) begin tick(); n++; end
    tick();
    bus.in_v = 1'b0;
    lat = 1;
    while (!bus.out_v && lat < BUDGET) begin tick(); lat++; end
    if (!bus.out_v || n >= BUDGET) timeout = 1'b1;
    repeat (stall) tick();
    res = bus.out0;
    mo  = bus.m_o;
    bus.out_r = 1'b1;
    tick();
    bus.out_r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.in_r !== 1'b1) begin errors++; $display("FAIL reset_in_r got %b want 1", bus.in_r); end
    checks++; if (bus.out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b want 0", bus.out_v); end
    checks++; if (bus.out0 !== '0) begin errors++; $display("FAIL reset_out0 got %h want 0", bus.out0); end
    checks++; if (bus.m_o !== '0) begin errors++; $display("FAIL reset_m_o got %h want 0", bus.m_o); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] res; logic [M-1:0] mo, m; int unsigned lat; bit to;
    m = rand_m();
    run_op(W'(2), W'(3), m, 0, res, mo, lat, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got timeout want result"); end
    checks++; if (res !== W'(6)) begin errors++; $display("FAIL basic_product got %h want 6", res); end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, W + 1); end
    checks++; if (mo !== m) begin errors++; $display("FAIL basic_meta got %h want %h", mo, m); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] res, a, b, exp; logic [M-1:0] mo; int unsigned lat; bit to;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin a = P_TB - 1'b1; b = P_TB - 1'b1; exp = W'(1);  end
        1: begin a = '1;          b = W'(1);       exp = W'(18); end
        2: begin a = '0;          b = rand_w();    exp = '0;     end
        3: begin a = W'(5);       b = P_TB;        exp = '0;     end
        default: begin a = W'(7); b = P_TB + 1'b1; exp = W'(7);  end
      endcase
      run_op(a, b, rand_m(), 0, res, mo, lat, to);
      checks++;
      if (to || res !== exp) begin
        errors++; $display("FAIL wrap_case%0d got %h want %h (timeout=%0d)", i, res, exp, to);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2, o; logic [M-1:0] m1, m2, mm; int unsigned n;
    a1 = rand_w(); b1 = rand_w(); m1 = rand_m();
    a2 = rand_w(); b2 = rand_w(); m2 = rand_m();
    bus.in0 = a1; bus.in1 = b1; bus.m_i = m1; bus.in_v = 1'b1;
    tick();
    bus.in0 = a2; bus.in1 = b2; bus.m_i = m2;
    n = 0;
    while (!bus.out_v && n < BUDGET) begin tick(); n++; end
    checks++; if (!bus.out_v) begin errors++; $display("FAIL bp_first_timeout got out_v=0 want 1"); end
    o = bus.out0; mm = bus.m_o;
    checks++; if (o !== ref_mul(a1, b1)) begin errors++; $display("FAIL bp_first_result got %h want %h", o, ref_mul(a1, b1)); end
    checks++; if (mm !== m1) begin errors++; $display("FAIL bp_first_meta got %h want %h", mm, m1); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.out_v !== 1'b1 || bus.out0 !== o || bus.m_o !== mm || bus.in_r !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_cycle%0d got v=%b r=%b out0=%h want v=1 r=0 out0=%h", i, bus.out_v, bus.in_r, bus.out0, o);
      end
    end
    bus.out_r = 1'b1;
    tick();
    bus.out_r = 1'b0;
    checks++; if (bus.in_r !== 1'b1 || bus.out_v !== 1'b0) begin errors++; $display("FAIL bp_after_handshake got in_r=%b out_v=%b want 1 0", bus.in_r, bus.out_v); end
    tick();
    bus.in_v = 1'b0;
    checks++; if (bus.in_r !== 1'b0) begin errors++; $display("FAIL bp_held_accept got in_r=%b want 0", bus.in_r); end
    n = 0;
    while (!bus.out_v && n < BUDGET) begin tick(); n++; end
    checks++; if (!bus.out_v || bus.out0 !== ref_mul(a2, b2) || bus.m_o !== m2) begin
      errors++; $display("FAIL bp_second_result got %h want %h", bus.out0, ref_mul(a2, b2));
    end
    bus.out_r = 1'b1;
    tick();
    bus.out_r = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] res; logic [M-1:0] mo; int unsigned lat; bit to;
    bus.in0 = rand_w(); bus.in1 = rand_w(); bus.m_i = rand_m(); bus.in_v = 1'b1;
    tick();
    bus.in_v = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.out_v !== 1'b0 || bus.in_r !== 1'b1) begin errors++; $display("FAIL midrst_flags got out_v=%b in_r=%b want 0 1", bus.out_v, bus.in_r); end
    checks++; if (bus.out0 !== '0 || bus.m_o !== '0) begin errors++; $display("FAIL midrst_outputs got out0=%h m_o=%h want 0 0", bus.out0, bus.m_o); end
    tick();
    rst = 1'b0;
    run_op(W'(3), W'(4), rand_m(), 0, res, mo, lat, to);
    checks++; if (to || res !== W'(12)) begin errors++; $display("FAIL midrst_product got %h want c (timeout=%0d)", res, to); end
    checks++; if (lat != W + 1) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res; logic [M-1:0] m, mo; int unsigned lat, n_out; bit to;
    logic [W+M-1:0] expq [$];
    logic [W+M-1:0] e;
    int errs_before;
    errs_before = errors;
    n_out = 0;
    for (int i = 0; i < N_RAND; i++) begin
      a = rand_w();
      b = rand_w();
      if ($urandom_range(0, 7) == 0) b = P_TB + W'($urandom_range(0, 18));
      if ($urandom_range(0, 7) == 0) a = P_TB - W'($urandom_range(1, 4));
      m = rand_m();
      repeat ($urandom_range(0, 2)) tick();
      expq.push_back({ref_mul(a, b), m});
      run_op(a, b, m, $urandom_range(0, 3), res, mo, lat, to);
      e = expq.pop_front();
      n_out++;
      checks++;
      if (to || {res, mo} !== e) begin
        errors++;
        $display("FAIL random_op%0d got %h/%h want %h/%h (timeout=%0d)", i, res, mo, e[W+M-1:M], e[M-1:0], to);
      end
      if (errors - errs_before > 5) break;
    end
    checks++; if (n_out != N_RAND || expq.size() != 0) begin errors++; $display("FAIL random_count got %0d want %0d", n_out, N_RAND); end
    tick();
    checks++; if (bus.out_v !== 1'b0) begin errors++; $display("FAIL random_no_duplicate got out_v=%b want 0", bus.out_v); end
  endtask

  initial begin
    bus.in_v  = 1'b0;
    bus.in0   = '0;
    bus.in1   = '0;
    bus.m_i   = '0;
    bus.out_r = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
